// File: rtl/acc_sequencer.sv
// Instruction sequencer for a 4-bit accumulator datapath.
// It drives an external ALU and the accumulator register control strobes, using an IDLE/EXEC/WRITE FSM.
module acc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic [3:0] instr_data,
  output logic [2:0] alu_oc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_f,
  output logic       reg_cl,
  output logic       reg_ld,
  output logic       reg_inc,
  output logic       reg_dec,
  output logic       reg_sr,
  output logic       reg_ir,
  output logic       reg_sl,
  output logic       reg_il,
  output logic [3:0] reg_in,
  input  logic [3:0] reg_out,
  output logic       rd_valid,
  output logic [3:0] rd_data,
  output logic       done,
  output logic [7:0] instr_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] data;
  } instr_t;

  logic [1:0] state;
  instr_t     cur;
  logic [3:0] result;
  logic [3:0] rd_hold;
  logic       accept;

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      result    <= '0;
      rd_hold   <= '0;
      instr_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cur   <= '{op: instr_op, data: instr_data};
          state <= instr_op[3] ? WRITE : EXEC;
        end
        EXEC: begin
          result <= alu_f;
          state  <= WRITE;
        end
        WRITE: begin
          state     <= IDLE;
          instr_cnt <= instr_cnt + 8'd1;
          if (cur.op == 4'b1111) rd_hold <= reg_out;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    instr_ready = (state == IDLE);
    alu_oc   = '0;
    alu_a    = '0;
    alu_b    = '0;
    reg_cl   = 1'b0;
    reg_ld   = 1'b0;
    reg_inc  = 1'b0;
    reg_dec  = 1'b0;
    reg_sr   = 1'b0;
    reg_ir   = 1'b0;
    reg_sl   = 1'b0;
    reg_il   = 1'b0;
    reg_in   = '0;
    rd_valid = 1'b0;
    rd_data  = rd_hold;
    done     = 1'b0;
    if (state == EXEC) begin
      alu_oc = cur.op[2:0];
      alu_a  = reg_out;
      alu_b  = cur.data;
    end
    if (state == WRITE) begin
      done = 1'b1;
      if (!cur.op[3]) begin
        reg_ld = 1'b1;
        reg_in = result;
      end else begin
        case (cur.op[2:0])
          3'b000: reg_cl = 1'b1;
          3'b001: begin reg_ld = 1'b1; reg_in = cur.data; end
          3'b010: reg_inc = 1'b1;
          3'b011: reg_dec = 1'b1;
          3'b100: begin reg_sr = 1'b1; reg_ir = cur.data[0]; end
          3'b101: begin reg_sl = 1'b1; reg_il = cur.data[0]; end
          3'b111: begin rd_valid = 1'b1; rd_data = reg_out; end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer.
// A behavioural accumulator and ALU close the loop around the sequencer.
module tb_acc_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = '0, instr_data = '0;
  logic [2:0] alu_oc;
  logic [3:0] alu_a, alu_b, alu_f;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [3:0] reg_in, reg_out, rd_data;
  logic       rd_valid, done;
  logic [7:0] instr_cnt;
  int         passed = 0, total = 0, done_seen;

  acc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_data(instr_data), .alu_oc(alu_oc), .alu_a(alu_a),
    .alu_b(alu_b), .alu_f(alu_f), .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc),
    .reg_dec(reg_dec), .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
    .reg_in(reg_in), .reg_out(reg_out), .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // accumulator sharing rst_n with the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       reg_out <= '0;
    else if (reg_cl)  reg_out <= '0;
    else if (reg_ld)  reg_out <= reg_in;
    else if (reg_inc) reg_out <= reg_out + 4'd1;
    else if (reg_dec) reg_out <= reg_out - 4'd1;
    else if (reg_sr)  reg_out <= {reg_ir, reg_out[3:1]};
    else if (reg_sl)  reg_out <= {reg_out[2:0], reg_il};
  end

  always_comb begin
    case (alu_oc)
      3'd0: alu_f = alu_a + alu_b;
      3'd1: alu_f = alu_a - alu_b;
      3'd2: alu_f = alu_a & alu_b;
      3'd3: alu_f = alu_a | alu_b;
      3'd4: alu_f = alu_a ^ alu_b;
      3'd5: alu_f = ~alu_a;
      3'd6: alu_f = alu_a;
      default: alu_f = alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // drive one instruction; returns #1 after the accept edge
  task automatic issue(input logic [3:0] op, input logic [3:0] data);
    @(negedge clk);
    chk("ready_before_issue", instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_data = data;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic run_reg(input logic [3:0] op, input logic [3:0] data);
    issue(op, data); tick();
  endtask

  task automatic read_chk(input string tag, input logic [3:0] exp);
    issue(4'hF, 4'h0);
    chk({tag, "_rd_valid"}, rd_valid, 1);
    chk({tag, "_rd_data"}, rd_data, exp);
    tick();
    chk({tag, "_rd_valid_off"}, rd_valid, 0);
    chk({tag, "_rd_hold"}, rd_data, exp);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_strobes", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}, 0);
    chk("rst_alu", {alu_oc, alu_a}, 0);
    @(negedge clk); rst_n = 1'b1;

    // load then read
    issue(4'b1001, 4'b0101);
    chk("ld_ready", instr_ready, 0);
    chk("ld_reg_ld", reg_ld, 1);
    chk("ld_reg_in", reg_in, 4'b0101);
    chk("ld_done", done, 1);
    tick();
    chk("ld_ready_back", instr_ready, 1);
    chk("ld_done_off", done, 0);
    chk("ld_cnt", instr_cnt, 1);
    read_chk("rd1", 4'b0101);
    chk("rd1_cnt", instr_cnt, 2);

    // ALU add: 0011 + 0110 = 1001, 3-cycle latency
    run_reg(4'b1001, 4'b0011);
    issue(4'b0000, 4'b0110);
    chk("exec_alu_a", alu_a, 4'b0011);
    chk("exec_alu_b", alu_b, 4'b0110);
    chk("exec_alu_oc", alu_oc, 3'b000);
    chk("exec_ready", instr_ready, 0);
    chk("exec_no_ld", reg_ld, 0);
    chk("exec_no_done", done, 0);
    tick();
    chk("alu_wr_ld", reg_ld, 1);
    chk("alu_wr_in", reg_in, 4'b1001);
    chk("alu_wr_done", done, 1);
    chk("alu_wr_ready", instr_ready, 0);
    chk("alu_wr_alu_zero", {alu_oc, alu_a, alu_b}, 0);
    tick();
    chk("alu_ready_3cyc", instr_ready, 1);
    // ALU sub wraps: 1001 - 1100 = 1101
    issue(4'b0001, 4'b1100);
    chk("sub_alu_oc", alu_oc, 3'b001);
    tick();
    chk("sub_wr_in", reg_in, 4'b1101);
    tick();
    read_chk("rd_sub", 4'b1101);

    // inc wrap and dec wrap
    run_reg(4'b1001, 4'b1111);
    issue(4'b1010, 4'h0);
    chk("inc_strobe", reg_inc, 1);
    chk("inc_onehot", {reg_cl, reg_ld, reg_dec, reg_sr, reg_sl}, 0);
    tick();
    read_chk("rd_inc", 4'b0000);
    issue(4'b1011, 4'h0);
    chk("dec_strobe", reg_dec, 1);
    tick();
    read_chk("rd_dec", 4'b1111);

    // shifts
    run_reg(4'b1001, 4'b1000);
    issue(4'b1100, 4'b0001);
    chk("sr_strobe", reg_sr, 1);
    chk("sr_ir", reg_ir, 1);
    chk("sr_no_ld", reg_ld, 0);
    tick();
    chk("sr_off", {reg_sr, reg_ir}, 0);
    read_chk("rd_sr", 4'b1100);
    issue(4'b1101, 4'b0000);
    chk("sl_strobe", reg_sl, 1);
    chk("sl_il", reg_il, 0);
    tick();
    read_chk("rd_sl", 4'b1000);

    // clear
    issue(4'b1000, 4'h0);
    chk("cl_strobe", reg_cl, 1);
    tick();
    read_chk("rd_cl", 4'b0000);

    // valid held with changing fields during EXEC/WRITE
    run_reg(4'b1001, 4'b0010);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'b0010; instr_data = 4'b0111;
    tick();
    chk("hold_exec_ready", instr_ready, 0);
    @(negedge clk);
    instr_op = 4'b1000; instr_data = 4'b1111;
    chk("hold_exec_oc", alu_oc, 3'b010);
    chk("hold_exec_b", alu_b, 4'b0111);
    tick();
    chk("hold_wr_ready", instr_ready, 0);
    chk("hold_wr_in", reg_in, 4'b0010);
    chk("hold_wr_no_cl", reg_cl, 0);
    @(negedge clk);
    instr_valid = 1'b0;
    tick();
    tick();
    chk("hold_cnt", instr_cnt, 8'd20);
    chk("hold_ready_idle", instr_ready, 1);
    read_chk("rd_hold", 4'b0010);

    // reset during EXEC abandons the instruction
    issue(4'b0000, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_cnt", instr_cnt, 0);
    chk("midrst_alu", alu_oc, 0);
    chk("midrst_rd", rd_data, 0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || reg_ld) done_seen++;
    end
    chk("midrst_no_ld_done", done_seen[7:0], 0);
    chk("midrst_cnt_after", instr_cnt, 0);
    chk("midrst_ready_after", instr_ready, 1);

    // 256 nops wrap the counter
    done_seen = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (instr_ready !== 1'b1) begin
        total++;
        $error("FAIL nop_ready: got %b want 1", instr_ready);
      end
      instr_valid = 1'b1; instr_op = 4'b1110; instr_data = 4'h0;
      tick();
      instr_valid = 1'b0;
      if (done) done_seen++;
      if (i == 254) begin
        tick();
        chk("nop_cnt_255", instr_cnt, 8'd255);
      end else tick();
    end
    chk("nop_cnt_wrap", instr_cnt, 0);
    chk("nop_done_pulses", done_seen[8:0] == 9'd256, 1);
    chk("nop_no_strobe", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, rd_valid}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed: data 4 bits, ALU opcode 3 bits, instruction opcode 4 bits, counter 8 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  upstream instruction present.
REQ-005 instr_ready  output  1  sequencer can accept an instruction this cycle.
REQ-006 instr_op  input  4  bit3=0: ALU instruction, bits[2:0] = ALU opcode; bit3=1: register instruction, bits[2:0] = reg op.
REQ-007 instr_data  input  4  immediate operand.
REQ-008 alu_oc  output  3, alu_a  output  4, alu_b  output  4  ALU operand drive.
REQ-009 alu_f  input  4  ALU combinational result.
REQ-010 reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il  output  1 each  register control strobes.
REQ-011 reg_in  output  4  register parallel-load data.
REQ-012 reg_out  input  4  register current value (accumulator).
REQ-013 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-014 rd_data  output  4  accumulator value returned by read instruction.
REQ-015 done  output  1  one-cycle pulse on completion of any instruction.
REQ-016 instr_cnt  output  8  count of completed instructions.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, WRITE; instr_ready SHALL be 1 exactly in IDLE.
REQ-018 Accept = instr_valid && instr_ready at a rising edge; instr_op and instr_data SHALL be captured only on accept; changes while not accepted SHALL be ignored.
REQ-019 Accept of ALU instruction: IDLE -> EXEC; accept of register instruction: IDLE -> WRITE; EXEC -> WRITE; WRITE -> IDLE unconditionally.
REQ-020 In EXEC: alu_oc = captured op[2:0], alu_a = reg_out, alu_b = captured data; alu_f SHALL be sampled into a result register at the EXEC->WRITE edge.
REQ-021 alu_oc/alu_a/alu_b SHALL be 0 outside EXEC.
REQ-022 In WRITE for ALU instruction: reg_ld=1, reg_in = sampled result (4-bit, wraps per ALU; no carry kept).
REQ-023 In WRITE for register instruction, reg op 000: reg_cl; 001: reg_ld with reg_in=data; 010: reg_inc; 011: reg_dec; 100: reg_sr with reg_ir=data[0]; 101: reg_sl with reg_il=data[0]; 110: no strobe (nop); 111: no strobe, rd_valid=1, rd_data=reg_out.
REQ-024 At most one of reg_cl/ld/inc/dec/sr/sl SHALL be 1 in any cycle; all strobes, reg_ir, reg_il and reg_in SHALL be 0 outside WRITE.
REQ-025 rd_data SHALL hold last read value between reads.
REQ-026 done SHALL be 1 for exactly the WRITE cycle; instr_cnt SHALL increment at the WRITE->IDLE edge, wrapping 255 -> 0.
REQ-027 Latency accept-to-ready: ALU instruction 3 cycles, register instruction 2 cycles; back-to-back throughput one instruction per 2 (reg) or 3 (ALU) cycles.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, captured op/data, result, rd_data, instr_cnt to 0 and all outputs to 0 except instr_ready.
REQ-029 instr_ready SHALL be 1 while in reset-released IDLE; an instruction in flight when rst_n falls SHALL be abandoned with no strobe, done or count.
REQ-030 rst_n SHALL be shared with the downstream register so accumulator and sequencer reset together.

Verification
REQ-031 Reset, then reg op 001 data 0101, then op 111 -> reg_ld with reg_in=0101 in WRITE; read gives rd_valid pulse, rd_data=0101; instr_cnt=2.
REQ-032 Accumulator=0011, ALU instr op 0xxx data 0110 -> EXEC shows alu_a=0011, alu_b=0110, alu_oc=xxx; WRITE cycle reg_ld=1, reg_in equals alu_f from EXEC; ready returns 3 cycles after accept.
REQ-033 Accumulator=1111, op 1010 (inc) then op 111 -> rd_data=0000 (wrap); op 1011 from 0000 -> 1111.
REQ-034 op 1100 data 0001 on 1000 -> reg_sr=1, reg_ir=1 for one cycle, result 1100; op 1101 data 0000 on 1100 -> 1000.
REQ-035 instr_valid held high with changing data during EXEC/WRITE -> no extra accept; only captured data used; ready low for the full instruction.
REQ-036 rst_n pulsed low in EXEC -> no reg_ld, no done, instr_cnt=0, instr_ready=1 on release; 256 nops -> instr_cnt wraps to 0.
